// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a shared N-digit 7-segment display.
// Each slot has a blanking interval, a PWM on-window, and frame-atomic shadow-to-active commits.
module seg7_scan_ctrl #(
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned SCAN_DIV    = 27000,
  parameter int unsigned BLANK_CYC   = 270,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     wr_en,
  input  logic [$clog2(N_DIG)-1:0] wr_addr,
  input  logic [7:0]               wr_data,
  input  logic                     commit,
  input  logic [3:0]               bright,
  output logic                     busy,
  output logic                     frame_tick,
  output logic [7:0]               seg,
  output logic [N_DIG-1:0]         dig
);

  localparam int unsigned TW   = $clog2(SCAN_DIV);
  localparam int unsigned IW   = $clog2(N_DIG);
  localparam int unsigned STEP = (SCAN_DIV - BLANK_CYC) / 15;

  localparam logic [7:0]       SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [N_DIG-1:0] DIG_OFF = DIG_ACT_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

  typedef enum logic [1:0] {
    PH_BLANK = 2'd0,
    PH_ON    = 2'd1,
    PH_OFF   = 2'd2
  } phase_t;

  logic [TW-1:0]    timer;
  logic [IW-1:0]    idx;
  logic [3:0]       bright_q;
  logic [7:0]       shadow [N_DIG];
  logic [7:0]       active [N_DIG];
  logic             pending;

  logic             slot_end;
  logic             last_dig;
  logic             wrap;
  logic             pending_nxt;
  logic             addr_ok;
  logic [31:0]      on_end;
  phase_t           phase;
  logic [7:0]       lit_seg;
  logic [N_DIG-1:0] lit_dig;
  logic [7:0]       seg_nxt;
  logic [N_DIG-1:0] dig_nxt;

  // Slot/frame boundary detection
  always_comb begin
    slot_end = (timer == TW'(SCAN_DIV - 1));
    last_dig = (idx == IW'(N_DIG - 1));
    wrap     = slot_end && last_dig;
    addr_ok  = (32'(wr_addr) < N_DIG);
    // A commit on the wrap cycle re-arms pending so it is applied at the following wrap
    pending_nxt = wrap ? commit : (pending || commit);
  end

  // Phase within the current slot, decoded from the slot timer
  always_comb begin
    on_end = BLANK_CYC + (32'(bright_q) * STEP);
    phase  = PH_OFF;
    if (32'(timer) < BLANK_CYC) begin
      phase = PH_BLANK;
    end else if (32'(timer) < on_end) begin
      phase = PH_ON;
    end
  end

  // Pin values for the current cycle, registered below
  always_comb begin
    lit_seg = 8'h00;
    lit_dig = '0;
    if (phase == PH_ON) begin
      lit_seg      = active[idx];
      lit_dig[idx] = 1'b1;
    end
    seg_nxt = SEG_ACT_LOW ? ~lit_seg : lit_seg;
    dig_nxt = DIG_ACT_LOW ? ~lit_dig : lit_dig;
  end

  // Slot timer, digit index and per-slot brightness latch
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      timer    <= '0;
      idx      <= '0;
      bright_q <= 4'd0;
    end else begin
      if (slot_end) begin
        timer <= '0;
        idx   <= last_dig ? '0 : idx + IW'(1);
      end else begin
        timer <= timer + TW'(1);
      end
      if (timer == '0) begin
        bright_q <= bright;
      end
    end
  end

  // Shadow writes; the active copy only changes on a frame wrap with a commit pending
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < int'(N_DIG); i++) begin
        shadow[i] <= 8'h00;
        active[i] <= 8'h00;
      end
      pending <= 1'b0;
    end else begin
      if (wrap && pending) begin
        for (int i = 0; i < int'(N_DIG); i++) begin
          active[i] <= shadow[i];
        end
      end
      if (wr_en && addr_ok) begin
        shadow[wr_addr] <= wr_data;
      end
      pending <= pending_nxt;
    end
  end

  // Registered pins and status
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      seg        <= SEG_OFF;
      dig        <= DIG_OFF;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dig        <= dig_nxt;
      busy       <= pending_nxt;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: cycle-count reference model, slot-level vector table,
// directed commit/reset corner cases and randomized traffic.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 34;
  localparam int BL    = 4;
  localparam int STEP  = 2;
  localparam int FRAME = SD * ND;

  logic       clk = 1'b0;
  logic       nrst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       commit;
  logic [3:0] bright;
  logic       busy;
  logic       frame_tick;
  logic [7:0] seg;
  logic [3:0] dig;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .N_DIG      (ND),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BL),
    .SEG_ACT_LOW(1'b1),
    .DIG_ACT_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .commit    (commit),
    .bright    (bright),
    .busy      (busy),
    .frame_tick(frame_tick),
    .seg       (seg),
    .dig       (dig)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: position in the scan follows from the cycle count since reset
  int         n;
  logic [7:0] m_shadow [ND];
  logic [7:0] m_active [ND];
  logic       m_pending;
  logic [3:0] m_bq;

  typedef struct {
    logic [3:0] bright;
    logic [3:0] exp_dig;
    logic [7:0] exp_seg;
    int         exp_on;
  } slot_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < ND; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_pending = 1'b0;
    m_bq      = 4'd0;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    commit  = 1'b0;
    wr_addr = 2'd0;
    wr_data = 8'h00;
  endtask

  // One clock: predict from model state and current inputs, clock the DUT, compare
  task automatic tick();
    int         t;
    int         i;
    bit         wrap;
    bit         on;
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    logic       e_busy;
    t     = n % SD;
    i     = (n / SD) % ND;
    wrap  = ((n % FRAME) == FRAME - 1);
    on    = (t >= BL) && (t < BL + int'(m_bq) * STEP);
    e_seg = on ? ~m_active[i] : 8'hFF;
    e_dig = 4'hF;
    if (on) e_dig[i] = 1'b0;
    if (t == 0) m_bq = bright;
    if (wrap && m_pending) begin
      for (int k = 0; k < ND; k++) m_active[k] = m_shadow[k];
    end
    if (wr_en) m_shadow[wr_addr] = wr_data;
    m_pending = wrap ? commit : (m_pending | commit);
    e_busy    = m_pending;
    n++;
    @(posedge clk);
    #1;
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dig", 32'(dig), 32'(e_dig));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("frame_tick", 32'(frame_tick), 32'(wrap));
  endtask

  task automatic run_until(input int pos);
    for (int k = 0; k < FRAME && (n % FRAME) != pos; k++) tick();
  endtask

  slot_vec_t  tbl [8];
  logic [7:0] pat [ND];

  initial begin
    int lit;
    int ticks;
    int dig_on;
    int on_cnt;
    int ghost;
    int stray;
    logic [3:0] dig_s10;

    pat[0] = 8'h3F; pat[1] = 8'h06; pat[2] = 8'h5B; pat[3] = 8'h4F;
    tbl[0] = '{4'd15, 4'b1110, 8'hC0, 30};
    tbl[1] = '{4'd15, 4'b1101, 8'hF9, 30};
    tbl[2] = '{4'd15, 4'b1011, 8'hA4, 30};
    tbl[3] = '{4'd15, 4'b0111, 8'hB0, 30};
    tbl[4] = '{4'd1,  4'b1110, 8'hC0, 2};
    tbl[5] = '{4'd0,  4'b1101, 8'hF9, 0};
    tbl[6] = '{4'd8,  4'b1011, 8'hA4, 16};
    tbl[7] = '{4'd1,  4'b0111, 8'hB0, 2};

    // Reset state
    nrst   = 1'b0;
    bright = 4'd0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg), 32'h FF);
    chk("rst_dig", 32'(dig), 32'h F);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    nrst = 1'b1;

    // Frame 0: load patterns and commit; display stays dark until the swap
    bright = 4'd15;
    lit    = 0;
    for (int k = 0; k < ND; k++) begin
      wr_en = 1'b1; wr_addr = 2'(k); wr_data = pat[k];
      tick();
      if (seg != 8'hFF) lit++;
    end
    idle();
    commit = 1'b1;
    tick();
    if (seg != 8'hFF) lit++;
    commit = 1'b0;
    chk("busy_after_commit", 32'(busy), 32'd1);
    for (int k = 0; k < FRAME && (n % FRAME) != 0; k++) begin
      tick();
      if (seg != 8'hFF) lit++;
    end
    chk("frame0_dark", 32'(lit), 32'd0);
    chk("frame0_tick", 32'(frame_tick), 32'd1);
    chk("busy_cleared", 32'(busy), 32'd0);

    // Slot-level vectors: brightness window length and digit/pattern per slot
    foreach (tbl[e]) begin
      bright = tbl[e].bright;
      on_cnt = 0; ghost = 0; stray = 0;
      for (int s = 0; s < SD; s++) begin
        tick();
        if (dig == tbl[e].exp_dig && seg == tbl[e].exp_seg) on_cnt++;
        if (s < BL && dig != 4'hF) ghost++;
        if (dig != 4'hF && dig != tbl[e].exp_dig) stray++;
      end
      chk($sformatf("slot%0d_on", e), 32'(on_cnt), 32'(tbl[e].exp_on));
      chk($sformatf("slot%0d_ghost", e), 32'(ghost), 32'd0);
      chk($sformatf("slot%0d_stray", e), 32'(stray), 32'd0);
    end

    // Bright 0: dark but scan and frame ticks continue
    bright = 4'd0;
    ticks = 0; dig_on = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      if (frame_tick) ticks++;
      if (dig != 4'hF) dig_on++;
    end
    chk("dark_ticks", 32'(ticks), 32'd2);
    chk("dark_dig", 32'(dig_on), 32'd0);

    // Write without commit leaves the display alone for several frames
    bright = 4'd15;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h77;
    tick();
    idle();
    for (int f = 0; f < 3; f++) begin
      run_until(2 * SD + 10);
      tick();
      chk("no_commit_seg", 32'(seg), 32'h A4);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    run_until(2 * SD + 10);
    tick();
    chk("commit_seg", 32'(seg), 32'h 88);

    // Commit on the wrap cycle with nothing pending: applied one frame later
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h6D;
    tick();
    idle();
    run_until(FRAME - 1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("wrap_commit_busy", 32'(busy), 32'd1);
    run_until(10);
    tick();
    chk("wrap_commit_old", 32'(seg), 32'h C0);
    run_until(10);
    tick();
    chk("wrap_commit_new", 32'(seg), 32'h 92);
    chk("wrap_commit_idle", 32'(busy), 32'd0);

    // Commit on the wrap cycle with one pending: swap now, second commit kept
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h7D;
    tick();
    idle();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    run_until(FRAME - 1);
    commit = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h07;
    tick();
    idle();
    chk("double_commit_busy", 32'(busy), 32'd1);
    run_until(10);
    tick();
    chk("double_commit_first", 32'(seg), 32'h 82);
    run_until(10);
    tick();
    chk("double_commit_second", 32'(seg), 32'h F8);
    chk("double_commit_idle", 32'(busy), 32'd0);

    // Asynchronous reset mid-slot of digit 2
    run_until(2 * SD + 17);
    tick();
    chk("pre_reset_dig", 32'(dig), 32'h B);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_seg", 32'(seg), 32'h FF);
    chk("async_dig", 32'(dig), 32'h F);
    chk("async_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();
    lit = 0;
    dig_s10 = 4'h0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (seg != 8'hFF) lit++;
      if (k == 10) dig_s10 = dig;
    end
    chk("post_reset_dark", 32'(lit), 32'd0);
    chk("post_reset_idx0", 32'(dig_s10), 32'h E);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      wr_en   = ($urandom_range(3) == 0);
      wr_addr = 2'($urandom_range(3));
      wr_data = 8'($urandom);
      commit  = ($urandom_range(40) == 0);
      if ($urandom_range(15) == 0) bright = 4'($urandom_range(15));
      tick();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
